// File: rtl/add7_main.sv
// rtl/add7_main.sv - seven-operand 64-bit adder tree with start/done handshake
// Optional stall through controlArr is built when MAIN_STALL_EN is defined.
module add7_main (
    input  logic        clk,
    input  logic        rst,
    input  logic        r_enable,
    input  logic        controlArr,
    input  logic [63:0] init_a,
    input  logic [63:0] init_b,
    input  logic [63:0] init_c,
    input  logic [63:0] init_d,
    input  logic [63:0] init_e,
    input  logic [63:0] init_f,
    input  logic [63:0] init_g,
    output logic        w_enable,
    output logic [63:0] result
);

    typedef enum logic [1:0] {IDLE, L1, L2, L3} state_t;

    state_t      r_state;
    logic [63:0] r_a, r_b, r_c, r_d, r_e, r_f, r_g;
    logic [63:0] r_p0, r_p1, r_p2, r_pg;
    logic [63:0] r_q0, r_q1;
    logic        w_stall;

`ifdef MAIN_STALL_EN
    assign w_stall = controlArr;
`else
    logic w_unused_ctrl;
    assign w_unused_ctrl = controlArr;
    assign w_stall       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            w_enable <= 1'b0;
            result   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_d      <= '0;
            r_e      <= '0;
            r_f      <= '0;
            r_g      <= '0;
            r_p0     <= '0;
            r_p1     <= '0;
            r_p2     <= '0;
            r_pg     <= '0;
            r_q0     <= '0;
            r_q1     <= '0;
        end else if (w_stall) begin
            // Frozen: every register holds, and IDLE refuses new starts.
            w_enable <= 1'b0;
        end else begin
            w_enable <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_enable) begin
                        r_a     <= init_a;
                        r_b     <= init_b;
                        r_c     <= init_c;
                        r_d     <= init_d;
                        r_e     <= init_e;
                        r_f     <= init_f;
                        r_g     <= init_g;
                        r_state <= L1;
                    end
                end
                L1: begin
                    r_p0    <= r_a + r_b;
                    r_p1    <= r_c + r_d;
                    r_p2    <= r_e + r_f;
                    r_pg    <= r_g;
                    r_state <= L2;
                end
                L2: begin
                    r_q0    <= r_p0 + r_p1;
                    r_q1    <= r_p2 + r_pg;
                    r_state <= L3;
                end
                L3: begin
                    result   <= r_q0 + r_q1;
                    w_enable <= 1'b1;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add7_main.sv
// tb/tb_add7_main.sv - directed self-checking bench for add7_main
// Stall scenario is exercised when MAIN_STALL_EN is defined.
module tb_add7_main;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r_enable = 1'b0;
    logic        controlArr = 1'b0;
    logic [63:0] init_a = '0, init_b = '0, init_c = '0, init_d = '0;
    logic [63:0] init_e = '0, init_f = '0, init_g = '0;
    logic        w_enable;
    logic [63:0] result;

    int checks = 0;
    int failures = 0;
    int pulses;
    logic [9:0] w_hist;

    add7_main dut (
        .clk(clk), .rst(rst), .r_enable(r_enable), .controlArr(controlArr),
        .init_a(init_a), .init_b(init_b), .init_c(init_c), .init_d(init_d),
        .init_e(init_e), .init_f(init_f), .init_g(init_g),
        .w_enable(w_enable), .result(result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input logic [63:0] va, vb, vc, vd, ve, vf, vg);
        init_a = va; init_b = vb; init_c = vc; init_d = vd;
        init_e = ve; init_f = vf; init_g = vg;
    endtask

    // Pulse a start, then verify done appears exactly at the third edge after it.
    task automatic run_op(input string tag, input logic [63:0] exp);
        r_enable = 1'b1;
        tick();
        r_enable = 1'b0;
        tick();
        check({tag, "_w_n1"}, {63'd0, w_enable}, 64'd0);
        tick();
        check({tag, "_w_n2"}, {63'd0, w_enable}, 64'd0);
        tick();
        check({tag, "_w_n3"}, {63'd0, w_enable}, 64'd1);
        check({tag, "_result"}, result, exp);
        tick();
        check({tag, "_w_n4"}, {63'd0, w_enable}, 64'd0);
        check({tag, "_hold"}, result, exp);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("reset_w", {63'd0, w_enable}, 64'd0);
        check("reset_result", result, 64'd0);

        set_ops(64'd123, 64'd234, 64'd345, 64'd456, 64'd567, 64'd678, 64'd789);
        run_op("nominal", 64'd3192);

        set_ops(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
        run_op("wrap_zero", 64'd0);

        set_ops({64{1'b1}}, {64{1'b1}}, {64{1'b1}}, {64{1'b1}},
                {64{1'b1}}, {64{1'b1}}, {64{1'b1}});
        run_op("wrap_all", 64'hFFFF_FFFF_FFFF_FFF9);

        // Operands change right after the latch edge.
        set_ops(64'd1, 64'd1, 64'd1, 64'd1, 64'd1, 64'd1, 64'd1);
        r_enable = 1'b1;
        tick();
        r_enable = 1'b0;
        set_ops(64'd100, 64'd100, 64'd100, 64'd100, 64'd100, 64'd100, 64'd100);
        tick();
        tick();
        tick();
        check("latch_w", {63'd0, w_enable}, 64'd1);
        check("latch_result", result, 64'd7);
        tick();

        // Re-trigger while in L2 must not queue a second computation.
        set_ops(64'd10, 64'd20, 64'd30, 64'd40, 64'd50, 64'd60, 64'd70);
        r_enable = 1'b1;
        tick();
        r_enable = 1'b0;
        tick();
        r_enable = 1'b1;
        pulses = 0;
        tick();
        r_enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (w_enable) pulses++;
            tick();
        end
        check("busy_pulses", 64'(pulses), 64'd1);
        check("busy_result", result, 64'd280);

        // Held start: done on held edges 4 and 8, third done at edge 12.
        set_ops(64'd2, 64'd2, 64'd2, 64'd2, 64'd2, 64'd2, 64'd2);
        r_enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            w_hist[i] = w_enable;
        end
        r_enable = 1'b0;
        check("held_pattern", {54'd0, w_hist}, 64'h088);
        tick();
        check("held_w11", {63'd0, w_enable}, 64'd0);
        tick();
        check("held_w12", {63'd0, w_enable}, 64'd1);
        check("held_result", result, 64'd14);
        tick();

        // Reset while in L2, then immediate restart.
        set_ops(64'd123, 64'd234, 64'd345, 64'd456, 64'd567, 64'd678, 64'd789);
        r_enable = 1'b1;
        tick();
        r_enable = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_w", {63'd0, w_enable}, 64'd0);
        check("rst_mid_result", result, 64'd0);
        set_ops(64'd3, 64'd3, 64'd3, 64'd3, 64'd3, 64'd3, 64'd3);
        run_op("after_rst", 64'd21);

`ifdef MAIN_STALL_EN
        // Five stalled cycles in L1 push done from edge 3 to edge 8.
        set_ops(64'd123, 64'd234, 64'd345, 64'd456, 64'd567, 64'd678, 64'd789);
        r_enable = 1'b1;
        tick();
        r_enable = 1'b0;
        controlArr = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (w_enable) pulses++;
        end
        controlArr = 1'b0;
        check("stall_no_w", 64'(pulses), 64'd0);
        tick();
        tick();
        check("stall_w_n7", {63'd0, w_enable}, 64'd0);
        tick();
        check("stall_w_n8", {63'd0, w_enable}, 64'd1);
        check("stall_result", result, 64'd3192);
        tick();
`else
        // controlArr has no effect in this build.
        set_ops(64'd123, 64'd234, 64'd345, 64'd456, 64'd567, 64'd678, 64'd789);
        controlArr = 1'b1;
        run_op("ctrl_ignored", 64'd3192);
        controlArr = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
